// File: rtl/regfile_clr_if.sv
// Bundles the read/write port signals of the register file.
// The master drives the addresses, write data and enable; the slave returns the read data and busy.
interface regfile_clr_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic [AW-1:0] rr1;
  logic [AW-1:0] rr2;
  logic [AW-1:0] wr;
  logic [DW-1:0] wd;
  logic          regwrite;
  logic [DW-1:0] rd1;
  logic [DW-1:0] rd2;
  logic          busy;

  modport master (
    output rr1, rr2, wr, wd, regwrite,
    input  rd1, rd2, busy
  );

  modport slave (
    input  rr1, rr2, wr, wd, regwrite,
    output rd1, rd2, busy
  );
endinterface

// File: rtl/regfile_clr.sv
// 2-read/1-write MIPS32 register file with combinational reads, an optional write bypass,
// an optional hardwired-zero r0, and a post-reset sequencer that zeroes every entry.
module regfile_clr #(
  parameter int DW      = 32,
  parameter int AW      = 5,
  parameter int ZERO_R0 = 1,
  parameter int BYPASS  = 1
) (
  input  logic         clk,
  input  logic         reset,
  regfile_clr_if.slave bus
);
  localparam int DEPTH  = 1 << AW;
  localparam bit ZERO_EN = (ZERO_R0 != 0);
  localparam bit BYP_EN  = (BYPASS != 0);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_e;

  state_e         state_q;
  logic [AW-1:0]  clr_idx_q;
  logic           busy_q;
  logic [DW-1:0]  mem_q [DEPTH];

  logic           ready;
  logic           wr_en;
  logic           byp1, byp2;
  logic           zero1, zero2;
  logic [DW-1:0]  rd1_d, rd2_d;

  assign ready = (state_q == S_READY);
  assign wr_en = ready && bus.regwrite && !reset && !(ZERO_EN && (bus.wr == '0));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_CLEAR;
      clr_idx_q <= '0;
      busy_q    <= 1'b1;
    end else begin
      unique case (state_q)
        S_CLEAR: begin
          clr_idx_q <= clr_idx_q + 1'b1;
          if (clr_idx_q == '1) begin
            state_q <= S_READY;
            busy_q  <= 1'b0;
          end
        end
        S_READY: begin
          state_q <= S_READY;
        end
        default: begin
          state_q <= S_CLEAR;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  // NOTE: the array has no reset branch; the clear sequencer zeroes it one entry per cycle instead.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == S_CLEAR) begin
        mem_q[clr_idx_q] <= '0;
      end else if (wr_en) begin
        mem_q[bus.wr] <= bus.wd;
      end
    end
  end

  assign zero1 = ZERO_EN && (bus.rr1 == '0);
  assign zero2 = ZERO_EN && (bus.rr2 == '0);
  assign byp1  = BYP_EN && ready && bus.regwrite && (bus.rr1 == bus.wr);
  assign byp2  = BYP_EN && ready && bus.regwrite && (bus.rr2 == bus.wr);

  // The r0 override takes priority over the bypass so a dropped write is never visible.
  // NOTE: each combinational output gets a default first so no latch can be inferred.
  always_comb begin
    rd1_d = mem_q[bus.rr1];
    if (!ready || zero1) begin
      rd1_d = '0;
    end else if (byp1) begin
      rd1_d = bus.wd;
    end
  end

  always_comb begin
    rd2_d = mem_q[bus.rr2];
    if (!ready || zero2) begin
      rd2_d = '0;
    end else if (byp2) begin
      rd2_d = bus.wd;
    end
  end

  assign bus.rd1  = rd1_d;
  assign bus.rd2  = rd2_d;
  assign bus.busy = busy_q;
endmodule
